// File: rtl/mem_add_pkg.sv
// Shared constants and state encoding for the memory-resident multi-byte adder.
package mem_add_pkg;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MAX_NBYTES = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/add8c.sv
// One byte of the ripple adder: 8-bit sum with carry in and carry out.
module add8c
  import mem_add_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              c_o
);
  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, c_i};
endmodule

// File: rtl/mem_add_sequencer.sv
// Walks two little-endian operands in the data memory byte by byte, adding with
// ripple carry and storing each sum byte before the next byte is read.
module mem_add_sequencer
  import mem_add_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
  output logic              result_zero
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [DATA_W-1:0] a_q, a_d, sum_q, sum_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic              carry_out_q, carry_out_d, result_zero_q, result_zero_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_c;
  logic [ADDR_W-1:0] idx_ext;

  assign idx_ext = {{(ADDR_W-IDX_W){1'b0}}, i_q};

  add8c u_add8c (
    .a_i  (a_q),
    .b_i  (mem_rdata),
    .c_i  (carry_q),
    .sum_o(add_sum),
    .c_o  (add_c)
  );

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    dst_d         = dst_q;
    a_d           = a_q;
    sum_d         = sum_q;
    carry_d       = carry_q;
    zero_d        = zero_q;
    carry_out_d   = carry_out_q;
    result_zero_d = result_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_a_d = src_a;
          src_b_d = src_b;
          dst_d   = dst;
          i_d     = '0;
          carry_d = 1'b0;
          zero_d  = 1'b1;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        a_d     = mem_rdata;
        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        sum_d   = add_sum;
        carry_d = add_c;
        if (add_sum != '0) zero_d = 1'b0;
        state_d = ST_WR;
      end
      ST_WR: begin
        // Flags are final once the last byte is stored, so publish them with done.
        if (i_q == LAST_IDX) begin
          carry_out_d   = carry_q;
          result_zero_d = zero_q;
          state_d       = ST_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = ST_RD_A;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      ST_RD_A: mem_addr = src_a_q + idx_ext;
      ST_RD_B: mem_addr = src_b_q + idx_ext;
      ST_WR:   mem_addr = dst_q + idx_ext;
      default: mem_addr = '0;
    endcase
  end

  assign mem_wdata   = (state_q == ST_WR) ? sum_q : '0;
  assign mem_store   = (state_q == ST_WR);
  assign busy        = (state_q == ST_RD_A) || (state_q == ST_RD_B) || (state_q == ST_WR);
  assign done        = (state_q == ST_DONE);
  assign carry_out   = carry_out_q;
  assign result_zero = result_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      dst_q         <= '0;
      a_q           <= '0;
      sum_q         <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      carry_out_q   <= 1'b0;
      result_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      dst_q         <= dst_d;
      a_q           <= a_d;
      sum_q         <= sum_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      carry_out_q   <= carry_out_d;
      result_zero_q <= result_zero_d;
    end
  end
endmodule

// File: tb/tb_mem_add_sequencer.sv
// Bench for mem_add_sequencer with a behavioural 256-byte memory and a result scoreboard.
module tb_mem_add_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_a = 8'd0, src_b = 8'd0, dst = 8'd0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_store, busy, done, carry_out, result_zero;

  logic [7:0] mem [256];
  logic [7:0] wr_log [$];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] sum;
    logic        c;
    logic        z;
  } exp_t;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  mem_add_sequencer #(.NBYTES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst        (dst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_store  (mem_store),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .carry_out  (carry_out),
    .result_zero(result_zero)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_store) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back(mem_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // restart_at: relative cycle in which start is pulsed again (0 = never).
  // rst_at: relative cycle during which rst_n is held low (0 = never).
  task automatic run_op(input string name, input logic [7:0] sa, input logic [7:0] sb,
                        input logic [7:0] ds, input int restart_at, input int rst_at);
    logic [15:0] a, b;
    logic [16:0] s;
    logic [7:0]  hi_before;
    logic [31:0] busy_m, store_m;
    exp_t        e, cur;
    int          done_rel, done_cnt;
    bit          pend;
    busy_m = '0; store_m = '0; done_rel = 0; done_cnt = 0; pend = 0;
    a = {mem[8'(sa + 8'd1)], mem[sa]};
    b = {mem[8'(sb + 8'd1)], mem[sb]};
    s = {1'b0, a} + {1'b0, b};
    e.d = ds; e.sum = s[15:0]; e.c = s[16]; e.z = (s[15:0] == 16'h0);
    hi_before = mem[8'(ds + 8'd1)];
    if (rst_at == 0) sb_q.push_back(e);
    wr_log.delete();

    @(negedge clk);
    src_a = sa; src_b = sb; dst = ds; start = 1'b1;
    for (int rel = 1; rel <= 12; rel++) begin
      @(negedge clk);
      if (rel == 1) begin
        src_a = 8'hEE; src_b = 8'hDD; dst = 8'hCC;
      end
      start = (restart_at != 0 && rel == restart_at);
      if (rst_at != 0 && rel == rst_at + 1) begin
        check_eq({name, "_busy_after_rst"}, 32'(busy), 32'd0);
        check_eq({name, "_store_after_rst"}, 32'(mem_store), 32'd0);
      end
      rst_n = !(rst_at != 0 && rel == rst_at);
      if (busy) busy_m[rel] = 1'b1;
      if (mem_store) store_m[rel] = 1'b1;
      if (pend) begin
        check_eq({name, "_carry_out"}, 32'(carry_out), 32'(cur.c));
        check_eq({name, "_result_zero"}, 32'(result_zero), 32'(cur.z));
        check_eq({name, "_byte0"}, 32'(mem[cur.d]), 32'(cur.sum[7:0]));
        check_eq({name, "_byte1"}, 32'(mem[8'(cur.d + 8'd1)]), 32'(cur.sum[15:8]));
        pend = 0;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        if (sb_q.size() > 0) begin
          cur  = sb_q.pop_front();
          pend = 1;
        end
      end
    end
    rst_n = 1'b1;

    if (rst_at == 0) begin
      check_eq({name, "_done_rel"}, 32'(done_rel), 32'd7);
      check_eq({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({name, "_busy_mask"}, busy_m, 32'h7E);
      check_eq({name, "_store_mask"}, store_m, 32'h48);
      check_eq({name, "_nwrites"}, 32'(wr_log.size()), 32'd2);
      check_eq({name, "_wr_addr0"}, (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hDEAD, 32'(ds));
      check_eq({name, "_wr_addr1"}, (wr_log.size() > 1) ? 32'(wr_log[1]) : 32'hDEAD,
               32'(8'(ds + 8'd1)));
      check_eq({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    end else begin
      check_eq({name, "_done_cnt"}, 32'(done_cnt), 32'd0);
      check_eq({name, "_store_mask"}, store_m, 32'h08);
      check_eq({name, "_nwrites"}, 32'(wr_log.size()), 32'd1);
      check_eq({name, "_byte0"}, 32'(mem[ds]), 32'(e.sum[7:0]));
      check_eq({name, "_byte1_untouched"}, 32'(mem[8'(ds + 8'd1)]), 32'(hi_before));
    end
    sb_q.delete();
    $display("op %s: A=%04h B=%04h dst=%0d sum=%04h c=%0b z=%0b done_cnt=%0d",
             name, a, b, ds, s[15:0], s[16], e.z, done_cnt);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 8'hA5;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_carry_out", 32'(carry_out), 32'd0);
    check_eq("rst_result_zero", 32'(result_zero), 32'd0);
    check_eq("rst_mem_store", 32'(mem_store), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[100] = 8'h01; mem[101] = 8'h04; mem[102] = 8'h01; mem[103] = 8'h05;
    run_op("basic", 8'd100, 8'd102, 8'd104, 0, 0);

    mem[110] = 8'hFF; mem[111] = 8'h00; mem[112] = 8'h01; mem[113] = 8'h00;
    run_op("ripple", 8'd110, 8'd112, 8'd114, 0, 0);

    mem[120] = 8'hFF; mem[121] = 8'hFF; mem[122] = 8'h01; mem[123] = 8'h00;
    run_op("overflow", 8'd120, 8'd122, 8'd124, 0, 0);

    mem[255] = 8'h04; mem[0] = 8'h03; mem[10] = 8'h02; mem[11] = 8'h01;
    run_op("wrap_alias", 8'd255, 8'd10, 8'd255, 0, 0);

    run_op("restart_ignored", 8'd100, 8'd102, 8'd130, 3, 0);

    mem[140] = 8'h34; mem[141] = 8'h12; mem[142] = 8'h01; mem[143] = 8'h01;
    run_op("abort", 8'd140, 8'd142, 8'd150, 0, 5);
    run_op("after_abort", 8'd140, 8'd142, 8'd150, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
